// File: rtl/axicb_slv_switch_ar_arbiter.sv
// Slave-side read switch: round-robin AR arbitration over the master
// switches, with an ordering FIFO of granted masters that steers the
// slave's in-order R bursts back to their originator.
module axicb_slv_switch_ar_arbiter #(
    parameter int MST_NB  = 4,
    parameter int ARCH_W  = 8,
    parameter int RCH_W   = 8,
    parameter int OSTD_AW = 3
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_arvalid,
    output logic [MST_NB-1:0]        i_arready,
    input  logic [MST_NB*ARCH_W-1:0] i_arch,
    output logic [MST_NB-1:0]        i_rvalid,
    input  logic [MST_NB-1:0]        i_rready,
    output logic [MST_NB-1:0]        i_rlast,
    output logic [RCH_W-1:0]         i_rch,
    output logic                     o_arvalid,
    input  logic                     o_arready,
    output logic [ARCH_W-1:0]        o_arch,
    input  logic                     o_rvalid,
    output logic                     o_rready,
    input  logic                     o_rlast,
    input  logic [RCH_W-1:0]         o_rch,
    output logic [OSTD_AW:0]         ostd_cnt
);

    localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
    localparam int KW    = IDX_W + 1;
    localparam int CW    = OSTD_AW + 1;
    localparam int DEPTH = 1 << OSTD_AW;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              r_state, w_state_nxt;
    logic [MST_NB-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]    r_rr, w_rr_nxt;
    logic                w_sel_found;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [ARCH_W-1:0]   w_arch_g;
    logic                w_push;
    logic                w_pop;

    logic [IDX_W-1:0]    r_fifo [DEPTH];
    logic [OSTD_AW-1:0]  r_wptr;
    logic [OSTD_AW-1:0]  r_rptr;
    logic [OSTD_AW:0]    r_cnt;
    logic                w_nempty;
    logic                w_full;
    logic [IDX_W-1:0]    w_head;

    // Round-robin pick: first requester at or above the pointer, wrapping
    always_comb begin
        logic [KW-1:0] v_k;
        v_k         = '0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int unsigned i = 0; i < MST_NB; i++) begin
            v_k = {1'b0, r_rr} + KW'(i);
            if (v_k >= KW'(MST_NB)) begin
                v_k = v_k - KW'(MST_NB);
            end
            if (!w_sel_found && i_arvalid[v_k[IDX_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = v_k[IDX_W-1:0];
            end
        end
    end

    // Payload mux for the granted master
    always_comb begin
        w_arch_g = '0;
        for (int unsigned k = 0; k < MST_NB; k++) begin
            if (r_gidx == IDX_W'(k)) begin
                w_arch_g = i_arch[k*ARCH_W +: ARCH_W];
            end
        end
    end

    // AR FSM next-state and outputs; full check only taken in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr;
        o_arvalid   = 1'b0;
        o_arch      = '0;
        i_arready   = '0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_found && !w_full) begin
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_sel_idx] = 1'b1;
                    w_gidx_nxt             = w_sel_idx;
                    w_state_nxt            = GRANT;
                end
            end
            GRANT: begin
                o_arvalid = |(i_arvalid & r_grant);
                o_arch    = w_arch_g;
                i_arready = r_grant & {MST_NB{o_arready}};
                if (o_arvalid && o_arready) begin
                    w_push      = 1'b1;
                    w_rr_nxt    = (r_gidx == IDX_W'(MST_NB - 1)) ? '0 : r_gidx + IDX_W'(1);
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // AR FSM state, grant and round-robin pointer registers
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Ordering FIFO storage; contents are don't-care while empty
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_gidx;
        end
    end

    // Ordering FIFO pointers and occupancy
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + OSTD_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + OSTD_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_nempty = |r_cnt;
    // Occupancy never exceeds DEPTH, so the MSB alone flags full
    assign w_full   = r_cnt[OSTD_AW];
    assign w_head   = r_fifo[r_rptr];
    assign w_pop    = o_rvalid & o_rready & o_rlast;
    assign i_rch    = o_rch;
    assign ostd_cnt = r_cnt;

    // R steering to the master at the FIFO head
    always_comb begin
        i_rvalid = '0;
        i_rlast  = '0;
        o_rready = 1'b0;
        if (w_nempty) begin
            i_rvalid[w_head] = o_rvalid;
            i_rlast[w_head]  = o_rlast;
            o_rready         = i_rready[w_head];
        end
    end

endmodule

// File: tb/tb_axicb_slv_switch_ar_arbiter.sv
// Scoreboard bench for axicb_slv_switch_ar_arbiter: directed AR/R traffic,
// expected grants and beats queued at issue time, monitors pop on handshakes.
module tb_axicb_slv_switch_ar_arbiter;

    localparam int MST_NB  = 4;
    localparam int ARCH_W  = 8;
    localparam int RCH_W   = 8;
    localparam int OSTD_AW = 3;

    logic                     aclk = 1'b0;
    logic                     srst = 1'b1;
    logic [MST_NB-1:0]        i_arvalid;
    logic [MST_NB-1:0]        i_arready;
    logic [MST_NB*ARCH_W-1:0] i_arch;
    logic [MST_NB-1:0]        i_rvalid;
    logic [MST_NB-1:0]        i_rready;
    logic [MST_NB-1:0]        i_rlast;
    logic [RCH_W-1:0]         i_rch;
    logic                     o_arvalid;
    logic                     o_arready;
    logic [ARCH_W-1:0]        o_arch;
    logic                     o_rvalid;
    logic                     o_rready;
    logic                     o_rlast;
    logic [RCH_W-1:0]         o_rch;
    logic [OSTD_AW:0]         ostd_cnt;

    axicb_slv_switch_ar_arbiter #(
        .MST_NB  (MST_NB),
        .ARCH_W  (ARCH_W),
        .RCH_W   (RCH_W),
        .OSTD_AW (OSTD_AW)
    ) dut (
        .aclk      (aclk),
        .srst      (srst),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_arch    (i_arch),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rlast   (i_rlast),
        .i_rch     (i_rch),
        .o_arvalid (o_arvalid),
        .o_arready (o_arready),
        .o_arch    (o_arch),
        .o_rvalid  (o_rvalid),
        .o_rready  (o_rready),
        .o_rlast   (o_rlast),
        .o_rch     (o_rch),
        .ostd_cnt  (ostd_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {logic [3:0] m; logic [7:0] d;} ar_exp_t;
    typedef struct packed {logic [3:0] m; logic [7:0] d; logic l;} r_exp_t;

    int        checks     = 0;
    int        failures   = 0;
    int        cyc        = 0;
    int        first_rise = 0;
    ar_exp_t   exp_ar[$];
    r_exp_t    exp_r[$];
    int        hs_cyc[$];
    logic [7:0] mq [MST_NB][$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Master AR model: holds each queued payload valid until its handshake
    initial begin
        i_arvalid = '0;
        i_arch    = '0;
        forever begin
            logic [MST_NB-1:0] hs;
            logic              was_idle;
            @(negedge aclk);
            hs = srst ? '0 : (i_arvalid & i_arready);
            @(posedge aclk);
            #1;
            was_idle = (i_arvalid == '0);
            for (int k = 0; k < MST_NB; k++) begin
                if (hs[k] && mq[k].size() > 0) void'(mq[k].pop_front());
                if (mq[k].size() > 0) begin
                    i_arvalid[k]                 = 1'b1;
                    i_arch[k*ARCH_W +: ARCH_W]   = mq[k][0];
                end else begin
                    i_arvalid[k]                 = 1'b0;
                    i_arch[k*ARCH_W +: ARCH_W]   = '0;
                end
            end
            if (was_idle && i_arvalid != '0) first_rise = cyc;
        end
    end

    // AR monitor
    always @(negedge aclk) begin
        if (!srst && o_arvalid && o_arready) begin
            if (exp_ar.size() == 0) begin
                check("ar_unexpected", 32'(o_arch), 32'hFFFF_FFFF);
            end else begin
                ar_exp_t e;
                e = exp_ar.pop_front();
                check("ar_grant", 32'(i_arready), 32'(1) << e.m);
                check("ar_arch", 32'(o_arch), 32'(e.d));
                hs_cyc.push_back(cyc);
            end
        end
    end

    // R monitor
    always @(negedge aclk) begin
        if (!srst && o_rvalid && o_rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 32'(i_rvalid), 32'hFFFF_FFFF);
            end else begin
                r_exp_t e;
                e = exp_r.pop_front();
                check("r_route", 32'(i_rvalid), 32'(1) << e.m);
                check("r_data", 32'(i_rch), 32'(e.d));
                check("r_last", 32'(i_rlast), e.l ? (32'(1) << e.m) : 32'(0));
            end
        end
    end

    task automatic issue(input int m, input logic [7:0] d);
        mq[m].push_back(d);
    endtask

    task automatic expect_ar(input int m, input logic [7:0] d);
        ar_exp_t e;
        e.m = 4'(m);
        e.d = d;
        exp_ar.push_back(e);
    endtask

    task automatic wait_ar(input int left, input string name);
        int b;
        b = 0;
        while (exp_ar.size() > left && b < 100) begin
            @(posedge aclk);
            #1;
            b++;
        end
        check(name, 32'(exp_ar.size()), 32'(left));
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        srst = 1'b0;
    endtask

    task automatic send_burst(input int m, input int n, input logic [7:0] base, input bit tog);
        for (int b = 0; b < n; b++) begin
            int     budget;
            bit     done;
            r_exp_t e;
            budget = 0;
            done   = 1'b0;
            e.m = 4'(m);
            e.d = base + 8'(b);
            e.l = (b == n - 1);
            o_rvalid = 1'b1;
            o_rch    = e.d;
            o_rlast  = e.l;
            exp_r.push_back(e);
            while (!done) begin
                @(negedge aclk);
                if (tog) begin
                    check("r_rready_mirror", 32'(o_rready), 32'(i_rready[m]));
                    check("r_valid_route", 32'(i_rvalid), 32'(1) << m);
                end
                done = o_rready;
                @(posedge aclk);
                #1;
                if (tog) i_rready = ~i_rready;
                budget++;
                if (!done && budget > 40) begin
                    check("r_timeout", 32'(o_rready), 32'(1));
                    void'(exp_r.pop_back());
                    done = 1'b1;
                end
            end
        end
        o_rvalid = 1'b0;
        o_rlast  = 1'b0;
        o_rch    = '0;
    endtask

    task automatic check_ostd(input string name, input int exp);
        @(negedge aclk);
        check(name, 32'(ostd_cnt), 32'(exp));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        o_arready = 1'b1;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;
        o_rch     = '0;
        i_rready  = '1;
        do_reset();

        // Reset state, with R valid present to prove routing is gated
        o_rvalid = 1'b1;
        @(negedge aclk);
        check("rst_o_arvalid", 32'(o_arvalid), 0);
        check("rst_i_arready", 32'(i_arready), 0);
        check("rst_i_rvalid", 32'(i_rvalid), 0);
        check("rst_i_rlast", 32'(i_rlast), 0);
        check("rst_o_rready", 32'(o_rready), 0);
        check("rst_ostd", 32'(ostd_cnt), 0);
        check("rst_o_arch", 32'(o_arch), 0);
        @(posedge aclk);
        #1;
        o_rvalid = 1'b0;

        // All four request at once: grants 0,1,2,3 every 2 cycles
        hs_cyc.delete();
        for (int k = 0; k < MST_NB; k++) begin
            issue(k, 8'hA0 + 8'(k));
            expect_ar(k, 8'hA0 + 8'(k));
        end
        wait_ar(0, "t1_ar_done");
        check_ostd("t1_ostd4", 4);
        check("t1_hs_count", 32'(hs_cyc.size()), 4);
        if (hs_cyc.size() >= 4) begin
            check("t1_latency", 32'(hs_cyc[0] - first_rise), 1);
            for (int i = 1; i < 4; i++) check("t1_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 2);
        end
        for (int k = 0; k < MST_NB; k++) send_burst(k, 1, 8'h30 + 8'(k), 1'b0);
        check_ostd("t1_ostd0", 0);

        // Master 2 twice, then 1 and 3 together: 2,2,3,1
        do_reset();
        issue(2, 8'hC0);
        issue(2, 8'hC1);
        expect_ar(2, 8'hC0);
        expect_ar(2, 8'hC1);
        wait_ar(0, "t2_first");
        issue(1, 8'hC2);
        issue(3, 8'hC3);
        expect_ar(3, 8'hC3);
        expect_ar(1, 8'hC2);
        wait_ar(0, "t2_second");
        check_ostd("t2_ostd4", 4);
        send_burst(2, 1, 8'h40, 1'b0);
        send_burst(2, 1, 8'h41, 1'b0);
        send_burst(3, 1, 8'h42, 1'b0);
        send_burst(1, 1, 8'h43, 1'b0);
        check_ostd("t2_ostd0", 0);

        // Slave stalls arready for 5 cycles: grant and payload stable
        do_reset();
        o_arready = 1'b0;
        issue(1, 8'hD1);
        issue(2, 8'hD2);
        expect_ar(1, 8'hD1);
        expect_ar(2, 8'hD2);
        begin
            int b;
            b = 0;
            @(negedge aclk);
            while (!o_arvalid && b < 20) begin
                @(negedge aclk);
                b++;
            end
        end
        check("t5_arvalid_seen", 32'(o_arvalid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge aclk);
            check("t5_arvalid_hold", 32'(o_arvalid), 1);
            check("t5_arch_hold", 32'(o_arch), 32'h00D1);
            check("t5_no_arready", 32'(i_arready), 0);
        end
        @(posedge aclk);
        #1;
        o_arready = 1'b1;
        wait_ar(0, "t5_done");
        send_burst(1, 1, 8'h44, 1'b0);
        send_burst(2, 1, 8'h45, 1'b0);
        check_ostd("t5_ostd0", 0);

        // Order 1,0; 4-beat burst with toggling rready[1], then 2-beat
        do_reset();
        issue(1, 8'hE1);
        expect_ar(1, 8'hE1);
        wait_ar(0, "t4_first");
        issue(0, 8'hE0);
        expect_ar(0, 8'hE0);
        wait_ar(0, "t4_second");
        i_rready = 4'b0010;
        send_burst(1, 4, 8'h50, 1'b1);
        check_ostd("t4_ostd1", 1);
        i_rready = '1;
        send_burst(0, 2, 8'h60, 1'b0);
        check_ostd("t4_ostd0", 0);

        // Fill all 8 slots; a ninth request waits until a burst completes
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < MST_NB; k++) begin
                issue(k, 8'h80 + 8'(8*r + k));
                expect_ar(k, 8'h80 + 8'(8*r + k));
            end
        end
        issue(1, 8'h9F);
        expect_ar(1, 8'h9F);
        wait_ar(1, "t3_fill");
        check_ostd("t3_ostd8", 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("t3_blocked", 32'(o_arvalid), 0);
        end
        @(posedge aclk);
        #1;
        send_burst(0, 4, 8'h70, 1'b0);
        @(negedge aclk);
        check("t3_ostd7", 32'(ostd_cnt), 7);
        @(negedge aclk);
        check("t3_grant_after_pop", 32'(o_arvalid), 1);
        @(negedge aclk);
        check("t3_ostd8_again", 32'(ostd_cnt), 8);
        @(posedge aclk);
        #1;
        wait_ar(0, "t3_done");

        // Reset mid-burst with 3 outstanding
        do_reset();
        issue(0, 8'hF0);
        issue(1, 8'hF1);
        issue(2, 8'hF2);
        expect_ar(0, 8'hF0);
        expect_ar(1, 8'hF1);
        expect_ar(2, 8'hF2);
        wait_ar(0, "t6_fill");
        check_ostd("t6_ostd3", 3);
        begin
            r_exp_t e;
            e.m = 4'd0;
            e.d = 8'hB0;
            e.l = 1'b0;
            exp_r.push_back(e);
            o_rvalid = 1'b1;
            o_rch    = 8'hB0;
            o_rlast  = 1'b0;
            @(posedge aclk);
            #1;
            srst  = 1'b1;
            o_rch = 8'hB1;
            @(posedge aclk);
            #1;
            srst = 1'b0;
            @(negedge aclk);
            check("t6_ostd0", 32'(ostd_cnt), 0);
            check("t6_no_rready", 32'(o_rready), 0);
            check("t6_no_rvalid", 32'(i_rvalid), 0);
            @(posedge aclk);
            #1;
            o_rvalid = 1'b0;
            o_rch    = '0;
        end
        issue(3, 8'hF3);
        issue(1, 8'hF4);
        expect_ar(1, 8'hF4);
        expect_ar(3, 8'hF3);
        wait_ar(0, "t6_rearb");
        send_burst(1, 1, 8'h90, 1'b0);
        send_burst(3, 1, 8'h91, 1'b0);
        check_ostd("t6_ostd_end", 0);

        check("sb_ar_empty", 32'(exp_ar.size()), 0);
        check("sb_r_empty", 32'(exp_r.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
